// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the stream demultiplexer.
// Imported by the top level and the lane buffer.
package stream_demux_pkg;

  localparam int ERR_CNT_W = 8;

  function automatic int sel_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/demux_lane_buf.sv
// One-entry valid/ready output register for a single demux lane.
// A load and a drain in the same cycle keep the lane full with new data.
module demux_lane_buf
  import stream_demux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         drain_ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         can_load
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign valid    = valid_q;
  assign data     = data_q;
  assign can_load = !valid_q || drain_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
    end else if (valid_q && drain_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Valid/ready stream demultiplexer: routes each accepted beat to the
// lane named by in_sel; out-of-range beats are dropped and counted.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int N_OUT = 4,
  parameter  int W     = 8,
  localparam int SEL_W = sel_w(N_OUT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  input  logic [SEL_W-1:0]   in_sel,
  output logic [N_OUT-1:0]   out_valid,
  input  logic [N_OUT-1:0]   out_ready,
  output logic [N_OUT*W-1:0] out_data,
  output logic               err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [N_OUT-1:0] hit;
  logic [N_OUT-1:0] load;
  logic [N_OUT-1:0] can_load;
  logic             sel_ok;
  logic             rdy_sel;
  logic             accept;
  logic             drop;

  logic                 err_q;
  logic [ERR_CNT_W-1:0] cnt_q;
  logic [ERR_CNT_W-1:0] cnt_d;

  always_comb begin
    hit     = '0;
    rdy_sel = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if ({1'b0, in_sel} == (SEL_W+1)'(k)) begin
        hit[k]  = 1'b1;
        rdy_sel = can_load[k];
      end
    end
  end

  // An unmatched select can only be out of range; such beats are
  // always accepted so a bad producer cannot wedge the stream.
  assign sel_ok   = |hit;
  assign in_ready = rst_n && (sel_ok ? rdy_sel : 1'b1);
  assign accept   = in_valid && in_ready;
  assign load     = hit & {N_OUT{accept}};
  assign drop     = accept && !sel_ok;

  for (genvar k = 0; k < N_OUT; k++) begin : g_lane
    demux_lane_buf #(.W(W)) u_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load[k]),
      .load_data   (in_data),
      .drain_ready (out_ready[k]),
      .valid       (out_valid[k]),
      .data        (out_data[k*W +: W]),
      .can_load    (can_load[k])
    );
  end

  always_comb begin
    cnt_d = cnt_q;
    if (drop && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= drop;
      cnt_q <= cnt_d;
    end
  end

  assign err     = err_q;
  assign err_cnt = cnt_q;

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: a 4-lane and a 3-lane instance share stimulus
// and are checked each cycle against a lane-slot model.
module tb_stream_demux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vin = 1'b0;
  logic [7:0] din = '0;
  logic [1:0] sel = '0;
  logic [3:0] ordy = '0;

  logic        rdy_a, err_a;
  logic [3:0]  ov_a;
  logic [31:0] od_a;
  logic [7:0]  cnt_a;

  logic        rdy_b, err_b;
  logic [2:0]  ov_b;
  logic [23:0] od_b;
  logic [7:0]  cnt_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stream_demux #(.N_OUT(4), .W(8)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(vin), .in_ready(rdy_a),
    .in_data(din), .in_sel(sel),
    .out_valid(ov_a), .out_ready(ordy),
    .out_data(od_a), .err(err_a), .err_cnt(cnt_a)
  );

  stream_demux #(.N_OUT(3), .W(8)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(vin), .in_ready(rdy_b),
    .in_data(din), .in_sel(sel),
    .out_valid(ov_b), .out_ready(ordy[2:0]),
    .out_data(od_b), .err(err_b), .err_cnt(cnt_b)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: each lane is a one-beat slot; beats go where in_sel says.
  bit         mv[2][4];
  logic [7:0] md[2][4];
  bit         merr[2];
  int         mcnt[2];
  int         NO[2] = '{4, 3};

  function automatic bit m_rdy(input int i);
    if (!rst_n) return 1'b0;
    if (int'(sel) >= NO[i]) return 1'b1;
    return !mv[i][sel] || ordy[sel];
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) begin
        mv[i][k] = 1'b0;
        md[i][k] = '0;
      end
      merr[i] = 1'b0;
      mcnt[i] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          for (int k = 0; k < 4; k++) begin
            mv[i][k] = 1'b0;
            md[i][k] = '0;
          end
          merr[i] = 1'b0;
          mcnt[i] = 0;
        end else begin
          bit acc;
          acc = vin && m_rdy(i);
          merr[i] = acc && int'(sel) >= NO[i];
          if (merr[i] && mcnt[i] < 255) mcnt[i]++;
          for (int k = 0; k < NO[i]; k++) begin
            if (acc && int'(sel) == k) begin
              mv[i][k] = 1'b1;
              md[i][k] = din;
            end else if (mv[i][k] && ordy[k]) begin
              mv[i][k] = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        logic [3:0]  ev, av;
        logic [31:0] ed, ad;
        ev = '0;
        ed = '0;
        for (int k = 0; k < NO[i]; k++) begin
          ev[k] = mv[i][k];
          ed[k*8 +: 8] = md[i][k];
        end
        if (i == 0) begin
          av = ov_a;
          ad = od_a;
          chk("a.out_valid", 64'(av), 64'(ev));
          chk("a.out_data", 64'(ad), 64'(ed));
          chk("a.err", 64'(err_a), 64'(merr[0]));
          chk("a.err_cnt", 64'(cnt_a), 64'(mcnt[0]));
          chk("a.in_ready", 64'(rdy_a), 64'(m_rdy(0)));
        end else begin
          av = {1'b0, ov_b};
          ad = {8'h00, od_b};
          chk("b.out_valid", 64'(av), 64'(ev));
          chk("b.out_data", 64'(ad), 64'(ed));
          chk("b.err", 64'(err_b), 64'(merr[1]));
          chk("b.err_cnt", 64'(cnt_b), 64'(mcnt[1]));
          chk("b.in_ready", 64'(rdy_b), 64'(m_rdy(1)));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst.out_valid", 64'(ov_a), 64'h0);
    chk("rst.err", 64'(err_a), 64'h0);
    chk("rst.err_cnt", 64'(cnt_a), 64'h0);
    tick();

    ordy = 4'hF;
    sel = 2'd2; din = 8'hA5; vin = 1'b1;
    #1 chk("a5.in_ready", 64'(rdy_a), 64'h1);
    tick();
    vin = 1'b0;
    chk("a5.out_valid", 64'(ov_a), 64'h4);
    chk("a5.data", 64'(od_a[23:16]), 64'hA5);
    tick();
    chk("a5.cleared", 64'(ov_a), 64'h0);

    sel = 2'd1;
    for (int j = 1; j <= 3; j++) begin
      din = 8'(j);
      vin = 1'b1;
      #1 chk("b2b.in_ready", 64'(rdy_a), 64'h1);
      tick();
      chk("b2b.data", 64'(od_a[15:8]), 64'(j));
      chk("b2b.valid", 64'(ov_a[1]), 64'h1);
    end
    vin = 1'b0;
    tick();

    ordy = 4'b0111;
    sel = 2'd3; din = 8'h11; vin = 1'b1;
    tick();
    din = 8'h22;
    #1 chk("bp.in_ready_lo", 64'(rdy_a), 64'h0);
    tick();
    chk("bp.hold", 64'(od_a[31:24]), 64'h11);
    chk("bp.valid", 64'(ov_a[3]), 64'h1);
    ordy = 4'hF;
    #1 chk("bp.in_ready_hi", 64'(rdy_a), 64'h1);
    tick();
    chk("bp.new", 64'(od_a[31:24]), 64'h22);
    vin = 1'b0;
    tick();

    ordy = 4'b1110;
    sel = 2'd0; din = 8'h55; vin = 1'b1;
    tick();
    sel = 2'd1; din = 8'h66;
    #1 chk("il.in_ready", 64'(rdy_a), 64'h1);
    tick();
    vin = 1'b0;
    chk("il.l0_valid", 64'(ov_a[0]), 64'h1);
    chk("il.l0_data", 64'(od_a[7:0]), 64'h55);
    chk("il.l1_data", 64'(od_a[15:8]), 64'h66);
    tick();
    chk("il.l0_kept", 64'(ov_a[0]), 64'h1);
    chk("il.l1_drain", 64'(ov_a[1]), 64'h0);

    ordy = 4'h0;
    sel = 2'd2; din = 8'h77; vin = 1'b1;
    tick();
    vin = 1'b0;
    tick();
    chk("ar.l2_full", 64'(ov_a[2]), 64'h1);
    rst_n = 1'b0;
    #1 chk("ar.out_valid", 64'(ov_a), 64'h0);
    chk("ar.in_ready", 64'(rdy_a), 64'h0);
    chk("ar.out_data", 64'(od_a), 64'h0);
    tick();
    rst_n = 1'b1;
    ordy = 4'hF;
    tick();

    sel = 2'd3; din = 8'h00; vin = 1'b1;
    #1 chk("n3.in_ready", 64'(rdy_b), 64'h1);
    tick();
    vin = 1'b0;
    chk("n3.err", 64'(err_b), 64'h1);
    chk("n3.err_cnt", 64'(cnt_b), 64'h1);
    chk("n3.out_valid", 64'(ov_b), 64'h0);
    tick();
    chk("n3.err_pulse", 64'(err_b), 64'h0);
    vin = 1'b1;
    repeat (300) tick();
    vin = 1'b0;
    tick();
    chk("n3.sat", 64'(cnt_b), 64'd255);

    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      if (!(vin && !rdy_a)) begin
        vin = ($urandom % 4) != 0;
        sel = 2'($urandom);
        din = 8'($urandom);
      end
      ordy = 4'($urandom) | 4'($urandom);
      tick();
    end
    vin = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- One-to-many counterpart of the course's 2:1 `mux`: a valid/ready stream demultiplexer.
- Routes each accepted input beat to the output lane selected by `in_sel`.
- Each lane has a one-entry output register, giving a registered output path and full throughput per lane.
- Used wherever a single producer feeds several consumers, e.g. splitting a command stream by destination.

Parameters:
- N_OUT, 4, number of output lanes; legal range 2..16.
- W, 8, data width in bits.
- SEL_W, $clog2(N_OUT), width of the lane-select field; derived, not overridden.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted this cycle when in_valid && in_ready.
- in_data  input  W  input payload.
- in_sel  input  SEL_W  destination lane index.
- out_valid  output  N_OUT  per-lane valid; bit k belongs to lane k.
- out_ready  input  N_OUT  per-lane consumer ready.
- out_data  output  N_OUT*W  flattened lane payloads; lane k occupies bits [k*W +: W].
- err  output  1  one-cycle pulse: an out-of-range beat was dropped.
- err_cnt  output  8  saturating count of dropped beats.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset asserted (any time, including mid-transfer):
  - out_valid = 0, out_data = 0, err = 0, err_cnt = 0.
  - All buffered beats are discarded.
  - in_ready is 0 while rst_n is low.
- Per-lane buffer k:
  - Holds one beat.
  - Lane k drains in any cycle where out_valid[k] && out_ready[k].
- in_ready is combinational from in_sel and out_ready:
  - in_sel < N_OUT: in_ready = !out_valid[in_sel] || out_ready[in_sel].
  - in_sel >= N_OUT (only possible when N_OUT is not a power of two): in_ready = 1.
- Accept to lane k (in_valid && in_ready, in_sel = k < N_OUT):
  - On the next edge, lane k loads in_data and out_valid[k] = 1.
  - Latency is 1 cycle from accept to out_valid.
- Simultaneous drain and load on lane k:
  - out_valid[k] stays 1 and out_data[k] takes the new beat.
  - Sustains 1 beat per cycle per lane.
- Drain without load: out_valid[k] clears on the next edge. out_data[k] holds its last value; it is don't-care to consumers.
- Stall: while out_valid[k] && !out_ready[k], out_data[k] is stable and lane k is not overwritten.
- Only one beat can be accepted per cycle, so lanes never contend. Other lanes drain independently of the input.
- Out-of-range beat (in_sel >= N_OUT) when accepted:
  - The beat is dropped.
  - err pulses high for exactly the next cycle.
  - err_cnt increments and saturates at 255.
- The producer must hold in_data and in_sel stable while in_valid && !in_ready. The block does not check this.
- No combinational path from in_valid or in_data to any output. The only combinational paths are out_ready and in_sel to in_ready.

Decomposition:
- Package stream_demux_pkg:
  - function sel_w(n) returning $clog2(n).
  - localparam ERR_CNT_W = 8.
- Sub-module demux_lane_buf (parameter W):
  - One-entry valid/ready register with inputs load, load_data, drain_ready.
  - Outputs valid, data, can_load.
  - Instantiated N_OUT times in a generate loop.
- Top level contains:
  - Select decode (one-hot load per lane).
  - in_ready mux.
  - err/err_cnt logic.

Test Plan:
- Reset then idle, N_OUT=4, W=8 -> out_valid=4'b0000, err=0, err_cnt=0. Assert rst_n low mid-stream with lane 2 full -> out_valid[2] clears immediately (asynchronous).
- Single beat in_data=8'hA5, in_sel=2, all out_ready=1 -> next cycle out_valid=4'b0100, out_data[2]=8'hA5; cleared the cycle after.
- Back-to-back lane 1 with out_ready[1]=1: beats 8'h01, 8'h02, 8'h03 on consecutive cycles -> in_ready stays 1; out_data[1] shows 01, 02, 03 on consecutive cycles.
- Backpressure: out_ready[3]=0, send 8'h11 then 8'h22 to lane 3 -> first accepted; in_ready=0 for the second; out_data[3] holds 11. Raise out_ready[3] -> 22 accepted the same cycle and visible next cycle.
- Interleaving while lane 0 is stalled: beat to lane 1 -> accepted (in_ready=1); lane 0 unaffected.
- N_OUT=3: in_sel=3 with in_valid -> in_ready=1, no out_valid change, err pulses 1 cycle, err_cnt=1. Send 300 such beats -> err_cnt=255.
